// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - 640x480@60Hz VGA timing generator
//
// Purpose:
//   Divides the system clock down to the pixel rate and walks a horizontal /
//   vertical scan position over the full raster (visible area plus porches
//   and sync).  Sync and display-enable are registered decodes of the
//   position the counters are about to take, so they change on the same edge
//   as pixelX/pixelY and cannot glitch.
//
// Ports:
//   clock      system clock, all state on the rising edge
//   reset      asynchronous active-low reset (0 = reset)
//   pixelTick  one-clock pulse, once every CLK_DIV clocks
//   pixelX     horizontal scan position, 0..H_TOTAL-1
//   pixelY     vertical scan position, 0..V_TOTAL-1
//   hsync      horizontal sync, active low
//   vsync      vertical sync, active low
//   videoOn    1 while the scan position is inside the visible area
//   lineTick   one-clock pulse on the last pixel of each line
//   frameTick  one-clock pulse on the last pixel of each frame

module vga_sync_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clock,
  input  logic       reset,
  output logic       pixelTick,
  output logic [9:0] pixelX,
  output logic [9:0] pixelY,
  output logic       hsync,
  output logic       vsync,
  output logic       videoOn,
  output logic       lineTick,
  output logic       frameTick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // CLK_DIV >= 2 keeps this at least one bit wide.
  localparam int DIV_W = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VISIBLE  = 10'(H_DISPLAY);
  localparam logic [9:0] V_VISIBLE  = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START   = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END     = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START   = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END     = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [DIV_W-1:0] divCount;
  logic [9:0]       hCount;
  logic [9:0]       vCount;
  logic [9:0]       hNext;
  logic [9:0]       vNext;
  logic             hsyncNext;
  logic             vsyncNext;
  logic             videoOnNext;

  // ------------------------------------------------------------------
  // Pixel-rate divider
  // ------------------------------------------------------------------
  assign pixelTick = (divCount == DIV_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      divCount <= '0;
    end else if (pixelTick) begin
      divCount <= '0;
    end else begin
      divCount <= divCount + DIV_ONE;
    end
  end

  // ------------------------------------------------------------------
  // Next scan position.  The counters only move on a pixel tick; the
  // vertical counter steps when the horizontal one wraps.
  // ------------------------------------------------------------------
  always_comb begin
    hNext = hCount;
    vNext = vCount;
    if (pixelTick) begin
      if (hCount == H_LAST) begin
        hNext = '0;
        vNext = (vCount == V_LAST) ? '0 : vCount + 10'd1;
      end else begin
        hNext = hCount + 10'd1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hCount <= '0;
      vCount <= '0;
    end else begin
      hCount <= hNext;
      vCount <= vNext;
    end
  end

  assign pixelX = hCount;
  assign pixelY = vCount;

  // ------------------------------------------------------------------
  // Sync / display-enable.  Decoding the next position and registering
  // it lines these outputs up with pixelX/pixelY with zero skew.
  // ------------------------------------------------------------------
  always_comb begin
    hsyncNext   = !((hNext >= HS_START) && (hNext < HS_END));
    vsyncNext   = !((vNext >= VS_START) && (vNext < VS_END));
    videoOnNext = (hNext < H_VISIBLE) && (vNext < V_VISIBLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      videoOn <= 1'b0;
    end else begin
      hsync   <= hsyncNext;
      vsync   <= vsyncNext;
      videoOn <= videoOnNext;
    end
  end

  // ------------------------------------------------------------------
  // Line / frame strobes, coincident with the tick on the last pixel.
  // ------------------------------------------------------------------
  assign lineTick  = pixelTick && (hCount == H_LAST);
  assign frameTick = lineTick && (vCount == V_LAST);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen
//
// Three instances share one clock and reset: the default 640x480 timing at
// CLK_DIV=4, the same raster at CLK_DIV=2, and a shrunken raster at
// CLK_DIV=2 small enough to cover whole frames, vsync and wrap-around.
// Expected outputs come from a closed-form model of edge count since reset.

module tb_vga_sync_gen;

  // Small raster: H_TOTAL = 30, V_TOTAL = 15, frame = 900 clocks.
  localparam int SD  = 2;
  localparam int SHD = 16, SHF = 4, SHS = 6, SHB = 4;
  localparam int SVD = 8,  SVF = 2, SVS = 2, SVB = 3;

  localparam logic [25:0] RESET_V = {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

  typedef struct packed {
    logic [25:0] a;
    logic [25:0] b;
    logic [25:0] c;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic       tickA, hsA, vsA, vonA, ltA, ftA;
  logic [9:0] xA, yA;
  logic       tickB, hsB, vsB, vonB, ltB, ftB;
  logic [9:0] xB, yB;
  logic       tickC, hsC, vsC, vonC, ltC, ftC;
  logic [9:0] xC, yC;

  int compareCount = 0;
  int failCount    = 0;

  exp_t sb[$];

  always #5 clock = ~clock;

  vga_sync_gen #(.CLK_DIV(4)) dutA (
    .clock(clock), .reset(reset), .pixelTick(tickA), .pixelX(xA), .pixelY(yA),
    .hsync(hsA), .vsync(vsA), .videoOn(vonA), .lineTick(ltA), .frameTick(ftA)
  );

  vga_sync_gen #(
    .CLK_DIV(SD), .H_DISPLAY(SHD), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_DISPLAY(SVD), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dutB (
    .clock(clock), .reset(reset), .pixelTick(tickB), .pixelX(xB), .pixelY(yB),
    .hsync(hsB), .vsync(vsB), .videoOn(vonB), .lineTick(ltB), .frameTick(ftB)
  );

  vga_sync_gen #(.CLK_DIV(2)) dutC (
    .clock(clock), .reset(reset), .pixelTick(tickC), .pixelX(xC), .pixelY(yC),
    .hsync(hsC), .vsync(vsC), .videoOn(vonC), .lineTick(ltC), .frameTick(ftC)
  );

  function automatic logic [25:0] obsA();
    return {tickA, xA, yA, hsA, vsA, vonA, ltA, ftA};
  endfunction
  function automatic logic [25:0] obsB();
    return {tickB, xB, yB, hsB, vsB, vonB, ltB, ftB};
  endfunction
  function automatic logic [25:0] obsC();
    return {tickC, xC, yC, hsC, vsC, vonC, ltC, ftC};
  endfunction

  // Outputs after the n-th rising edge since reset release (n >= 1).
  // The position advances on edges where n is a multiple of d, so after
  // edge n the raster index is n/d.
  function automatic logic [25:0] model(int n, int d, int hd, int hf, int hs, int hb,
                                        int vd, int vf, int vs, int vb);
    int ht, vt, p, x, y;
    logic tick, hsn, vsn, von, lt, ft;
    logic [9:0] xv, yv;
    ht   = hd + hf + hs + hb;
    vt   = vd + vf + vs + vb;
    p    = n / d;
    x    = p % ht;
    y    = (p / ht) % vt;
    tick = ((n % d) == d - 1);
    hsn  = !((x >= hd + hf) && (x < hd + hf + hs));
    vsn  = !((y >= vd + vf) && (y < vd + vf + vs));
    von  = (x < hd) && (y < vd);
    lt   = tick && (x == ht - 1);
    ft   = lt && (y == vt - 1);
    xv   = 10'(x);
    yv   = 10'(y);
    return {tick, xv, yv, hsn, vsn, von, lt, ft};
  endfunction

  function automatic exp_t expect_all(int n);
    exp_t e;
    e.a = model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    e.b = model(n, SD, SHD, SHF, SHS, SHB, SVD, SVF, SVS, SVB);
    e.c = model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33);
    return e;
  endfunction

  task automatic check(input string tag, input logic [25:0] observed,
                       input logic [25:0] expected);
    compareCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_all(input string tag);
    check({tag, "_A"}, obsA(), RESET_V);
    check({tag, "_B"}, obsB(), RESET_V);
    check({tag, "_C"}, obsC(), RESET_V);
  endtask

  // Advance one edge, push the model's prediction, pop and compare on the
  // falling edge.
  task automatic step(input int n, input string phase);
    exp_t e;
    @(posedge clock);
    sb.push_back(expect_all(n));
    @(negedge clock);
    e = sb.pop_front();
    check({phase, "_A"}, obsA(), e.a);
    check({phase, "_B"}, obsB(), e.b);
    check({phase, "_C"}, obsC(), e.c);
  endtask

  initial begin
    int lineA, lineB, frameB, lineC, lastLineC, periodC;
    lineA = 0; lineB = 0; frameB = 0; lineC = 0; lastLineC = -1; periodC = -1;

    // Reset held for 5 clocks.
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check_reset_all("in_reset");
    end

    // Release; nothing changes until the first edge.
    reset = 1'b1;
    #1;
    check_reset_all("released");

    // One-plus lines on the full rasters, two-plus frames on the small one.
    for (int n = 1; n <= 3300; n++) begin
      step(n, "run");
      if (ltA) lineA++;
      if (n <= 1800) begin
        if (ltB) lineB++;
        if (ftB) frameB++;
      end
      if (ltC) begin
        lineC++;
        if (lastLineC >= 0) periodC = n - lastLineC;
        lastLineC = n;
      end
    end

    check("line_ticks_A", 26'(lineA), 26'd1);
    check("line_ticks_B_2frames", 26'(lineB), 26'd30);
    check("frame_ticks_B_2frames", 26'(frameB), 26'd2);
    check("line_ticks_C", 26'(lineC), 26'd2);
    check("line_period_C", 26'(periodC), 26'd1600);

    // Restart and run into the small raster's hsync and vsync region.
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_all("reset2");
    reset = 1'b1;
    for (int n = 1; n <= 709; n++) begin
      step(n, "pre_mid");
    end
    check("mid_sync_B", {24'd0, hsB, vsB}, 26'd0);
    check("mid_pos_B", {6'd0, xB, yB}, {6'd0, 10'd24, 10'd11});

    // Assert reset away from any clock edge; outputs must drop at once.
    #1;
    reset = 1'b0;
    #1;
    check_reset_all("async_reset");
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_reset_all("held_reset");
    end

    reset = 1'b1;
    #1;
    check_reset_all("released2");
    for (int n = 1; n <= 200; n++) begin
      step(n, "restart");
    end

    check("scoreboard_empty", 26'(sb.size()), 26'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
